brick_hit_detector: RTL and testbench

- Reader-side counterpart to the brick-store writer: scans the 256x18 brick RAM for the brick containing the ball position and reports the first live hit.
- On a hit, it clears that brick's colour field in RAM so the brick counts as destroyed.
- It returns the brick's x, y and colour so the control FSM can run ERASE_BRICK.
- It sits between the ball-motion logic (MOVE_BALL) and the shared brick RAM port.

---
 rtl/brick_hit_detector.sv | 163 ++++++++++++++++
 tb/tb_brick_hit_detector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_hit_detector.sv
// brick_hit_detector
// Scans the brick RAM for the first live brick that contains the ball,
// clears that brick's colour so it counts as destroyed, and reports the
// brick's position and original colour for the erase pass.
module brick_hit_detector #(
  parameter int NUM_BRICKS = 40,
  parameter int BRICK_W    = 16,
  parameter int BRICK_H    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ball_x,
  input  logic [6:0]  ball_y,
  output logic [7:0]  ram_address,
  input  logic [17:0] ram_q,
  output logic        ram_wren,
  output logic [17:0] ram_data,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [7:0]  hit_index,
  output logic [7:0]  hit_x,
  output logic [6:0]  hit_y,
  output logic [2:0]  hit_colour
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    CLEAR,
    DONE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_BRICKS - 1);
  localparam logic [8:0] WIDTH9   = 9'(BRICK_W);
  localparam logic [7:0] HEIGHT8  = 8'(BRICK_H);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  ballX_q, ballX_d;
  logic [6:0]  ballY_q, ballY_d;
  logic        hit_q, hit_d;
  logic [7:0]  hitIndex_q, hitIndex_d;
  logic [7:0]  hitX_q, hitX_d;
  logic [6:0]  hitY_q, hitY_d;
  logic [2:0]  hitColour_q, hitColour_d;

  logic        brickLive;
  logic        inX;
  logic        inY;
  logic [8:0]  ballX9;
  logic [8:0]  brickX9;
  logic [7:0]  ballY8;
  logic [7:0]  brickY8;

  // Containment test against the entry currently on ram_q, widened so edge bricks never wrap
  always_comb begin
    ballX9    = {1'b0, ballX_q};
    brickX9   = {1'b0, ram_q[7:0]};
    ballY8    = {1'b0, ballY_q};
    brickY8   = {1'b0, ram_q[14:8]};
    brickLive = (ram_q[17:15] != 3'b000);
    inX       = (ballX9 >= brickX9) && (ballX9 < (brickX9 + WIDTH9));
    inY       = (ballY8 >= brickY8) && (ballY8 < (brickY8 + HEIGHT8));
  end

  // Next-state logic: walk the entries in order and stop at the first live hit
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ballX_d     = ballX_q;
    ballY_d     = ballY_q;
    hit_d       = hit_q;
    hitIndex_d  = hitIndex_q;
    hitX_d      = hitX_q;
    hitY_d      = hitY_q;
    hitColour_d = hitColour_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ballX_d     = ball_x;
          ballY_d     = ball_y;
          idx_d       = 8'd0;
          hit_d       = 1'b0;
          hitIndex_d  = 8'd0;
          hitX_d      = 8'd0;
          hitY_d      = 7'd0;
          hitColour_d = 3'd0;
          state_d     = READ;
        end
      end
      READ: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (brickLive && inX && inY) begin
          hit_d       = 1'b1;
          hitIndex_d  = idx_q;
          hitX_d      = ram_q[7:0];
          hitY_d      = ram_q[14:8];
          hitColour_d = ram_q[17:15];
          state_d     = CLEAR;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      CLEAR: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset abandons any scan in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 8'd0;
      ballX_q     <= 8'd0;
      ballY_q     <= 7'd0;
      hit_q       <= 1'b0;
      hitIndex_q  <= 8'd0;
      hitX_q      <= 8'd0;
      hitY_q      <= 7'd0;
      hitColour_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ballX_q     <= ballX_d;
      ballY_q     <= ballY_d;
      hit_q       <= hit_d;
      hitIndex_q  <= hitIndex_d;
      hitX_q      <= hitX_d;
      hitY_q      <= hitY_d;
      hitColour_q <= hitColour_d;
    end
  end

  // Idx already equals the hit index during CLEAR, so it drives the address in both phases
  always_comb begin
    ram_address = idx_q;
    ram_wren    = (state_q == CLEAR);
    ram_data    = (state_q == CLEAR) ? {3'b000, hitY_q, hitX_q} : 18'd0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    hit         = hit_q;
    hit_index   = hitIndex_q;
    hit_x       = hitX_q;
    hit_y       = hitY_q;
    hit_colour  = hitColour_q;
  end

endmodule

// File: tb/tb_brick_hit_detector.sv
// tb_brick_hit_detector
// Drives scans against a modelled brick RAM and compares every result with
// a first-match reference computed directly from the brick geometry.
module tb_brick_hit_detector;

  localparam int NUM_BRICKS = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ball_x;
  logic [6:0]  ball_y;
  logic [7:0]  ram_address;
  logic [17:0] ram_q;
  logic        ram_wren;
  logic [17:0] ram_data;
  logic        busy;
  logic        done;
  logic        hit;
  logic [7:0]  hit_index;
  logic [7:0]  hit_x;
  logic [6:0]  hit_y;
  logic [2:0]  hit_colour;

  logic [17:0] ramMem [256];
  logic [17:0] refMem [256];
  logic        loadReq;

  int compared   = 0;
  int mismatched = 0;

  brick_hit_detector #(
    .NUM_BRICKS(NUM_BRICKS),
    .BRICK_W(16),
    .BRICK_H(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .ram_address(ram_address),
    .ram_q(ram_q),
    .ram_wren(ram_wren),
    .ram_data(ram_data),
    .busy(busy),
    .done(done),
    .hit(hit),
    .hit_index(hit_index),
    .hit_x(hit_x),
    .hit_y(hit_y),
    .hit_colour(hit_colour)
  );

  always #5 clk = ~clk;

  // Standard wall: ten bricks per row, 16 px apart, rows 8 px apart, colours cycling 1..7
  function automatic logic [17:0] layoutEntry(input int k);
    if (k >= NUM_BRICKS) return 18'd0;
    return {3'((k % 7) + 1), 7'((k / 10) * 8), 8'((k % 10) * 16)};
  endfunction

  // Single-port synchronous brick RAM with a bulk preload
  always @(posedge clk) begin
    if (loadReq) begin
      for (int i = 0; i < 256; i++) ramMem[i] <= layoutEntry(i);
    end else if (ram_wren) begin
      ramMem[ram_address] <= ram_data;
    end
    ram_q <= ramMem[ram_address];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic reloadRam();
    loadReq = 1'b1;
    @(posedge clk); #1;
    loadReq = 1'b0;
    for (int i = 0; i < 256; i++) refMem[i] = layoutEntry(i);
  endtask

  task automatic checkRamContents(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < NUM_BRICKS; i++)
      if (ramMem[i] !== refMem[i]) diffs++;
    checkOutput(tag, diffs, 0);
  endtask

  // Reference: first live brick whose rectangle holds the ball; it is then destroyed
  task automatic predictScan(input int bx, input int by, output int expHit, output int expIdx,
                             output int expX, output int expY, output int expCol, output int expDone);
    expHit = 0; expIdx = 0; expX = 0; expY = 0; expCol = 0;
    expDone = 2 * NUM_BRICKS + 1;
    for (int k = 0; k < NUM_BRICKS; k++) begin
      int col, bxl, byt;
      col = int'(refMem[k][17:15]);
      byt = int'(refMem[k][14:8]);
      bxl = int'(refMem[k][7:0]);
      if (col != 0 && bx >= bxl && bx < bxl + 16 && by >= byt && by < byt + 4) begin
        expHit = 1; expIdx = k; expX = bxl; expY = byt; expCol = col;
        expDone = 2 * k + 4;
        refMem[k][17:15] = 3'd0;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int bx, input int by, input bit extraStart);
    int expHit, expIdx, expX, expY, expCol, expDone;
    int cycle, doneCycle, wrenCount, wrenCycle, busyGaps, extraDones;
    logic [7:0]  wrenAddr;
    logic [17:0] wrenData;
    predictScan(bx, by, expHit, expIdx, expX, expY, expCol, expDone);
    wrenCount = 0; wrenCycle = -1; wrenAddr = '0; wrenData = '0;
    busyGaps = 0; doneCycle = -1;
    ball_x = 8'(bx);
    ball_y = 7'(by);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycle = 1;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        doneCycle = cycle;
        break;
      end
      if (!busy) busyGaps++;
      if (ram_wren) begin
        wrenCount++;
        wrenCycle = cycle;
        wrenAddr  = ram_address;
        wrenData  = ram_data;
      end
      start = (extraStart && cycle == 5);
      @(posedge clk); #1;
      cycle++;
    end
    start = 1'b0;
    checkOutput("done_cycle", doneCycle, expDone);
    checkOutput("busy_during_scan", busyGaps, 0);
    checkOutput("busy_at_done", busy, 1);
    checkOutput("wren_at_done", ram_wren, 0);
    checkOutput("hit", hit, expHit);
    checkOutput("hit_index", hit_index, expIdx);
    checkOutput("hit_x", hit_x, expX);
    checkOutput("hit_y", hit_y, expY);
    checkOutput("hit_colour", hit_colour, expCol);
    checkOutput("wren_count", wrenCount, expHit);
    if (expHit != 0) begin
      checkOutput("wren_cycle", wrenCycle, expDone - 1);
      checkOutput("wren_addr", wrenAddr, expIdx);
      checkOutput("wren_data", wrenData, {14'd0, 3'b000, 7'(expY), 8'(expX)});
    end
    @(posedge clk); #1;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("busy_after", busy, 0);
    checkOutput("hit_held", hit, expHit);
    if (extraStart) begin
      extraDones = 0;
      for (int c = 0; c < 100; c++) begin
        if (done || busy) extraDones++;
        @(posedge clk); #1;
      end
      checkOutput("ignored_start", extraDones, 0);
    end
    checkRamContents("ram_contents");
  endtask

  // Abort a scan with reset part way through and confirm nothing was written
  task automatic resetMidScan(input int bx, input int by);
    ball_x = 8'(bx);
    ball_y = 7'(by);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_hit", hit, 0);
    checkOutput("abort_wren", ram_wren, 0);
    checkOutput("abort_addr", ram_address, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_no_done", done, 0);
    checkRamContents("abort_ram");
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    loadReq = 1'b0;
    ball_x  = '0;
    ball_y  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_hit", hit, 0);
    checkOutput("rst_addr", ram_address, 0);
    checkOutput("rst_wren", ram_wren, 0);
    checkOutput("rst_data", ram_data, 0);
    checkOutput("rst_hit_fields", {hit_index, hit_x, 9'd0, hit_y, hit_colour}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed scans");
    reloadRam();
    applyStimulus(37, 10, 1'b0);
    applyStimulus(37, 10, 1'b1);
    reloadRam();
    applyStimulus(15, 3, 1'b0);
    reloadRam();
    applyStimulus(16, 3, 1'b0);
    applyStimulus(5, 5, 1'b0);
    applyStimulus(159, 27, 1'b0);

    $display("[TB] reset during scan");
    reloadRam();
    resetMidScan(37, 10);
    applyStimulus(37, 10, 1'b0);

    $display("[TB] random scans");
    reloadRam();
    for (int n = 0; n < 40; n++) begin
      if (n % 12 == 11) reloadRam();
      applyStimulus(int'($urandom_range(159, 0)), int'($urandom_range(35, 0)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
